// File: rtl/seg_avg_filter.sv
// Segmented averaging filter: splits each frame of qualified samples into NUM_SEG
// segments of 2^LOG2_LEN samples and publishes all segment averages together.
module seg_avg_filter #(
  parameter int DATA_W   = 12,
  parameter int LOG2_LEN = 3,
  parameter int NUM_SEG  = 2,
  parameter int SIGNED   = 0,
  parameter int ROUND    = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      sync_clr,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in,
  output logic                      out_ready,
  output logic [NUM_SEG*DATA_W-1:0] out_bus
);

  localparam int ACC_W = DATA_W + LOG2_LEN + 1;
  localparam int CNT_W = LOG2_LEN;
  localparam int SEG_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_LEN) - 1);
  localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NUM_SEG - 1);
  localparam logic [ACC_W-1:0] RND_C    = (ROUND != 0) ? (ACC_W'(1) << (LOG2_LEN - 1)) : {ACC_W{1'b0}};

  logic [CNT_W-1:0]          cnt_r;
  logic [SEG_W-1:0]          seg_cnt_r;
  logic [ACC_W-1:0]          acc_r;
  logic [NUM_SEG*DATA_W-1:0] stage_r;
  logic [ACC_W-1:0]          ext_s;
  logic [ACC_W-1:0]          sum_s;
  logic [DATA_W-1:0]         avg_s;
  logic [NUM_SEG*DATA_W-1:0] stage_next_s;
  logic [NUM_SEG*DATA_W-1:0] bus_next_s;

  // Rounded, shifted segment mean; arithmetic shift keeps negative sums floored.
  function automatic logic [DATA_W-1:0] avg_f(input logic [ACC_W-1:0] sum);
    logic [ACC_W-1:0] t;
    logic [ACC_W-1:0] sh;
    t = sum + RND_C;
    if (SIGNED != 0) begin
      sh = ACC_W'($signed(t) >>> LOG2_LEN);
    end else begin
      sh = t >> LOG2_LEN;
    end
    avg_f = DATA_W'(sh);
  endfunction

  assign ext_s = {{(LOG2_LEN + 1){(SIGNED != 0) & in[DATA_W-1]}}, in};
  assign sum_s = acc_r + ext_s;
  assign avg_s = avg_f(sum_s);

  // Staging update for the current slot and the bus image with the fresh last slot.
  always_comb begin
    stage_next_s = stage_r;
    for (int k = 0; k < NUM_SEG; k++) begin
      if (seg_cnt_r == SEG_W'(k)) begin
        stage_next_s[k*DATA_W +: DATA_W] = avg_s;
      end else begin
        stage_next_s[k*DATA_W +: DATA_W] = stage_r[k*DATA_W +: DATA_W];
      end
    end
    bus_next_s = stage_r;
    bus_next_s[(NUM_SEG-1)*DATA_W +: DATA_W] = avg_s;
  end

  // Sample/segment counting, accumulation, staging and frame publication.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r     <= {CNT_W{1'b0}};
      seg_cnt_r <= {SEG_W{1'b0}};
      acc_r     <= {ACC_W{1'b0}};
      stage_r   <= {(NUM_SEG*DATA_W){1'b0}};
      out_bus   <= {(NUM_SEG*DATA_W){1'b0}};
      out_ready <= 1'b0;
    end else if (sync_clr) begin
      cnt_r     <= {CNT_W{1'b0}};
      seg_cnt_r <= {SEG_W{1'b0}};
      acc_r     <= {ACC_W{1'b0}};
      out_ready <= 1'b0;
    end else begin
      out_ready <= 1'b0;
      if (in_valid) begin
        if (cnt_r == LAST_CNT) begin
          acc_r   <= {ACC_W{1'b0}};
          cnt_r   <= {CNT_W{1'b0}};
          stage_r <= stage_next_s;
          if (seg_cnt_r == LAST_SEG) begin
            seg_cnt_r <= {SEG_W{1'b0}};
            out_bus   <= bus_next_s;
            out_ready <= 1'b1;
          end else begin
            seg_cnt_r <= seg_cnt_r + SEG_W'(1);
          end
        end else begin
          acc_r <= sum_s;
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_avg_filter.sv
// Self-checking bench: four filter variants (signed/unsigned x floor/round) share
// one stimulus stream and are compared against a frame-level arithmetic model.
module tb_seg_avg_filter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sync_clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = 12'd0;
  logic [3:0]  obs_rdy;
  logic [23:0] obs_bus [4];

  int errors = 0;
  int checks = 0;
  int frame_q[$];
  logic [23:0] exp_bus [4];
  logic        exp_rdy;

  always #5 clk = ~clk;

  seg_avg_filter #(.SIGNED(0), .ROUND(0)) u_s0r0 (.clk(clk), .reset_n(reset_n), .sync_clr(sync_clr),
    .in_valid(in_valid), .in(in_data), .out_ready(obs_rdy[0]), .out_bus(obs_bus[0]));
  seg_avg_filter #(.SIGNED(0), .ROUND(1)) u_s0r1 (.clk(clk), .reset_n(reset_n), .sync_clr(sync_clr),
    .in_valid(in_valid), .in(in_data), .out_ready(obs_rdy[1]), .out_bus(obs_bus[1]));
  seg_avg_filter #(.SIGNED(1), .ROUND(0)) u_s1r0 (.clk(clk), .reset_n(reset_n), .sync_clr(sync_clr),
    .in_valid(in_valid), .in(in_data), .out_ready(obs_rdy[2]), .out_bus(obs_bus[2]));
  seg_avg_filter #(.SIGNED(1), .ROUND(1)) u_s1r1 (.clk(clk), .reset_n(reset_n), .sync_clr(sync_clr),
    .in_valid(in_valid), .in(in_data), .out_ready(obs_rdy[3]), .out_bus(obs_bus[3]));

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Mean of eight samples, floor division with optional half-up rounding.
  function automatic logic [11:0] seg_mean(input int sum, input bit rnd);
    int t;
    int q;
    t = sum + (rnd ? 4 : 0);
    q = t / 8;
    if ((t % 8 != 0) && (t < 0)) q = q - 1;
    return 12'(q);
  endfunction

  function automatic int sample_val(input int raw, input bit sgn);
    if (sgn && raw >= 2048) return raw - 4096;
    return raw;
  endfunction

  task automatic model_frame();
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 2; k++) begin
        int sum;
        sum = 0;
        for (int j = 0; j < 8; j++) sum += sample_val(frame_q[k*8 + j], c >= 2);
        exp_bus[c][k*12 +: 12] = seg_mean(sum, (c % 2) == 1);
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("%s_rdy%0d", tag, c), {23'd0, obs_rdy[c]}, {23'd0, exp_rdy});
      check($sformatf("%s_bus%0d", tag, c), obs_bus[c], exp_bus[c]);
    end
  endtask

  // One clock: drive, let the edge happen, advance the model, check.
  task automatic step(input bit v, input int d, input bit clr);
    in_valid = v;
    in_data  = 12'(d);
    sync_clr = clr;
    @(posedge clk);
    exp_rdy = 1'b0;
    if (clr) begin
      frame_q.delete();
    end else if (v) begin
      frame_q.push_back(d);
      if (frame_q.size() == 16) begin
        model_frame();
        exp_rdy = 1'b1;
        frame_q.delete();
      end
    end
    #1;
    check_all("step");
    in_valid = 1'b0;
    sync_clr = 1'b0;
  endtask

  initial begin
    for (int c = 0; c < 4; c++) exp_bus[c] = 24'd0;
    exp_rdy = 1'b0;
    #2;
    check_all("reset");
    #10 reset_n = 1'b1;

    // Ramp 1..16 gapless
    for (int i = 1; i <= 16; i++) step(1'b1, i, 1'b0);
    step(1'b0, 0, 1'b0);
    check("ramp_const", obs_bus[0], 24'h00C004);

    // Full scale and round-half-up
    for (int i = 0; i < 16; i++) step(1'b1, 4095, 1'b0);
    check("full_scale_r1", obs_bus[1], 24'hFFFFFF);
    for (int i = 0; i < 16; i++) step(1'b1, (i < 8) ? 4 : 5, 1'b0);
    check("round_45", obs_bus[1], 24'h005004);

    // Signed: -1 x4, 0 x4, -3 x8
    for (int i = 0; i < 16; i++) step(1'b1, (i < 4) ? 4095 : ((i < 8) ? 0 : 4093), 1'b0);
    check("signed_r0", obs_bus[2], 24'hFFDFFF);
    check("signed_r1", obs_bus[3], 24'hFFD000);

    // Ramp with random valid gaps
    for (int i = 1; i <= 16; i++) begin
      int gap;
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) step(1'b0, $urandom_range(0, 4095), 1'b0);
      step(1'b1, i, 1'b0);
    end
    step(1'b0, 0, 1'b0);
    check("gap_const", obs_bus[0], 24'h00C004);

    // sync_clr mid-frame with a colliding valid sample
    for (int i = 0; i < 5; i++) step(1'b1, 2000 + i, 1'b0);
    step(1'b1, 999, 1'b1);
    check("clr_hold", obs_bus[0], 24'h00C004);
    for (int i = 1; i <= 16; i++) step(1'b1, i, 1'b0);
    check("clr_then_ramp", obs_bus[0], 24'h00C004);

    // Random frames with short gaps, back-to-back boundary included
    for (int i = 0; i < 48; i++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 0, 1'b0);
      step(1'b1, $urandom_range(0, 4095), 1'b0);
    end

    // Asynchronous reset mid-segment, unaligned to the clock
    for (int i = 0; i < 3; i++) step(1'b1, 77, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    frame_q.delete();
    for (int c = 0; c < 4; c++) exp_bus[c] = 24'd0;
    exp_rdy = 1'b0;
    check_all("async_rst");
    #9 reset_n = 1'b1;
    for (int i = 1; i <= 16; i++) step(1'b1, i, 1'b0);
    check("post_rst_ramp", obs_bus[0], 24'h00C004);
    step(1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_avg_filter.md
Name: seg_avg_filter

Overview:
- Parametrised successor to the two-slot 12-bit average filter.
- Accepts a qualified stream of ADC samples and splits each frame into NUM_SEG consecutive segments of 2^LOG2_LEN samples.
- Averages each segment, then presents all segment averages together on one registered bus with a single-cycle done pulse.
- Sits between the ADC capture interface and the range/FFT front end. Adds a valid qualifier, signed mode, rounding and a synchronous frame restart.

Parameters:
- DATA_W, 12: sample and average width in bits.
- LOG2_LEN, 3: log2 of samples per segment (default 8 samples).
- NUM_SEG, 2: segments per frame; must be >= 1.
- SIGNED, 0: 0 = unsigned samples; 1 = two's-complement samples, using arithmetic shift.
- ROUND, 0: 0 = truncate (floor); 1 = round half up, adding 2^(LOG2_LEN-1) before the shift.

Ports:
- clk, in, 1: sole clock; all state changes on the rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- sync_clr, in, 1: synchronous frame restart.
- in_valid, in, 1: sample qualifier.
- in, in, DATA_W: sample data; sampled only when in_valid=1.
- out_ready, out, 1: one-cycle pulse marking a completed frame.
- out_bus, out, NUM_SEG*DATA_W: segment averages; segment k occupies bits [k*DATA_W +: DATA_W].

Behaviour:
- Reset (reset_n=0, asynchronous, no clock needed): sample counter, segment counter, accumulator, staging registers, out_bus and out_ready all go to 0.
- Accumulator width: DATA_W+LOG2_LEN+1 bits. Samples are sign-extended when SIGNED=1, zero-extended otherwise. No wrap is possible.
- Average = (sum + rnd) >> LOG2_LEN, where rnd is 0 or 2^(LOG2_LEN-1) and the shift is arithmetic when SIGNED=1. Keep the low DATA_W bits. The result always lies within the input range, so no saturation logic is needed.
- On every edge with in_valid=1 and sync_clr=0:
  - The sample is added to the accumulator.
  - The sample counter increments.
- Not the last sample of a segment: the accumulator keeps the running sum.
- Last sample of a segment (sample count = 2^LOG2_LEN-1):
  - Average of (acc+in) is written to staging slot seg_cnt.
  - Accumulator clears and the sample counter wraps to 0.
- Last sample of the last segment (seg_cnt = NUM_SEG-1), on the same edge:
  - out_bus loads all staging slots, with the final slot taken directly from the fresh average.
  - out_ready is set to 1.
  - seg_cnt wraps to 0.
- Latency: out_ready and the new out_bus are visible in the cycle immediately after the edge that accepted the frame's last sample.
- out_ready is high for exactly one cycle. out_bus holds until the next frame completes.
- in_valid=0: all counters, accumulator and staging hold. Gaps of any length give results identical to a gapless stream.
- sync_clr=1:
  - Sample counter, segment counter and accumulator clear on that edge.
  - A sample presented with in_valid on the same edge is discarded; clear wins.
  - out_bus is not changed and out_ready is forced to 0 on that edge.
- reset_n asserted mid-frame: the partial frame is lost. After release, accumulation starts fresh at segment 0, sample 0.
- NUM_SEG=1: every segment completion updates out_bus and pulses out_ready.
- Back-to-back frames with in_valid held high: out_ready pulses once every NUM_SEG*2^LOG2_LEN accepted samples, with no dead cycle.

Test Plan:
- Defaults, in_valid held high, samples 1..16:
  - out_ready pulses exactly once, one cycle after sample 16 is accepted.
  - out_bus[11:0]=4 (36/8) and out_bus[23:12]=12 (100/8).
- Defaults with ROUND=1, 16 samples of 4095 → both slots 4095, no wrap. Then 8 samples of 4 followed by 8 samples of 5, ROUND=1 → slot0=4, slot1=5.
- SIGNED=1, ROUND=0:
  - Slot 0 gets samples -1,-1,-1,-1,0,0,0,0 (sum -4) → slot0 = 0xFFF (-1).
  - Slot 1 gets eight samples of -3 → slot1 = 0xFFD.
  - Repeat with ROUND=1 → slot0 = 0, slot1 = 0xFFD.
- Same 16-sample stream as the first test, with in_valid randomly deasserted (up to 5-cycle gaps) → identical out_bus, and exactly one out_ready pulse.
- sync_clr after 5 accepted samples, asserted alongside a valid sample, then samples 1..16:
  - The discarded sample is not counted.
  - out_bus keeps its old value until the new frame completes, then shows 4 and 12.
- reset_n pulsed low for 10 ns, not aligned to clk, mid-segment → out_bus and out_ready read 0 immediately. A subsequent full frame gives correct averages.
